// File: rtl/nn_bus_mux.sv
// -----------------------------------------------------------------------------
// nn_bus_mux
//   N-to-1 front end for the neural-network block bus. NCH independent
//   drivers share one NN block. Arbitration is round-robin, and the grant is
//   held while the NN block stalls with bus_stop. Read completions (pushout)
//   are routed back to the channel that issued the read. An in-order owner
//   FIFO records which channel owns each outstanding read.
//
//   The request path and the response path are both combinational. The only
//   state is the round-robin pointer, the grant lock, the owner FIFO and the
//   sticky error flag.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   m_sel/m_rw      per-channel request and direction (1 = read)
//   m_addr/m_din    flattened per-channel address / write data
//   m_dout          read data, broadcast to every channel
//   m_bus_stop      per-channel stall
//   m_pushout       per-channel read-data-valid
//   s_*             single bus toward the NN block
//   err_unexp       sticky: pushout arrived with no read outstanding
//
// Optional build macro NN_BUS_MUX_STATS_EN
//   Adds the ports stat_acc and stat_stall. Each is NCH*16 bits and holds a
//   16-bit wrapping counter per channel: stat_acc counts accepted transfers,
//   stat_stall counts stalled request cycles.
// -----------------------------------------------------------------------------
module nn_bus_mux #(
   parameter int NCH      = 4,
   parameter int AW       = 20,
   parameter int DW       = 32,
   parameter int RD_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    m_sel,
   input  logic [NCH-1:0]    m_rw,
   input  logic [NCH*AW-1:0] m_addr,
   input  logic [NCH*DW-1:0] m_din,
   output logic [DW-1:0]     m_dout,
   output logic [NCH-1:0]    m_bus_stop,
   output logic [NCH-1:0]    m_pushout,
   output logic              s_sel,
   output logic              s_rw,
   output logic [AW-1:0]     s_addr,
   output logic [DW-1:0]     s_din,
   input  logic [DW-1:0]     s_dout,
   input  logic              s_bus_stop,
   input  logic              s_pushout,
   output logic              err_unexp
`ifdef NN_BUS_MUX_STATS_EN
   ,
   output logic [NCH*16-1:0] stat_acc,
   output logic [NCH*16-1:0] stat_stall
`endif
);

   localparam int CW = $clog2(NCH);
   localparam int PW = $clog2(RD_DEPTH);

   typedef logic [CW-1:0] ch_t;
   typedef enum logic {UNLOCKED, LOCKED} state_t;

   state_t        state_q, state_d;
   ch_t           rr_ptr, lock_ch, win_ch;
   logic          win_valid, accept, stall, push, pop;
   logic [CW:0]   scan_sum;
   logic [NCH-1:0] eligible;
   logic [AW-1:0] addr_arr [NCH];
   logic [DW-1:0] din_arr  [NCH];

   ch_t           owner_mem [RD_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;

   // Unpack the flattened buses. A channel is eligible if it is a write, or
   // if the registered count still has room for another read.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         addr_arr[i] = m_addr[i*AW +: AW];
         din_arr[i]  = m_din[i*DW +: DW];
         eligible[i] = m_sel[i] & (~m_rw[i] | (count < (PW+1)'(RD_DEPTH)));
      end
   end

   // Winner selection. While locked, the stalled channel keeps the bus. If
   // that channel drops m_sel, the bus goes idle and the lock is kept.
   // NOTE: every variable is given a default before any branch so that no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      win_ch    = lock_ch;
      win_valid = 1'b0;
      scan_sum  = '0;
      if (state_q == LOCKED) begin
         win_valid = m_sel[lock_ch];
      end else begin
         for (int k = 0; k < NCH; k++) begin
            scan_sum = {1'b0, rr_ptr} + (CW+1)'(k);
            if (scan_sum >= (CW+1)'(NCH))
               scan_sum = scan_sum - (CW+1)'(NCH);
            if (!win_valid && eligible[scan_sum[CW-1:0]]) begin
               win_valid = 1'b1;
               win_ch    = scan_sum[CW-1:0];
            end
         end
      end
      if (reset)
         win_valid = 1'b0;
   end

   assign s_sel  = win_valid;
   assign s_rw   = win_valid ? m_rw[win_ch]     : 1'b0;
   assign s_addr = win_valid ? addr_arr[win_ch] : '0;
   assign s_din  = win_valid ? din_arr[win_ch]  : '0;
   assign m_dout = s_dout;

   assign accept = win_valid & ~s_bus_stop;
   assign stall  = win_valid &  s_bus_stop;
   assign push   = accept & m_rw[win_ch];
   assign pop    = s_pushout & (count != '0);

   // Every requester except the channel accepted this cycle sees a stall.
   // m_pushout is a one-hot decode of the owner at the head of the FIFO.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         m_bus_stop[i] = m_sel[i] & ~(accept && (win_ch == CW'(i)));
         m_pushout[i]  = pop && (owner_mem[rd_ptr] == CW'(i));
      end
   end

   // Next-state logic for the grant lock.
   always_comb begin
      state_d = state_q;
      case (state_q)
         UNLOCKED: if (stall)  state_d = LOCKED;
         LOCKED:   if (accept) state_d = UNLOCKED;
         default:  state_d = UNLOCKED;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   // Every flop then samples values from before the clock edge, so the
   // result does not depend on the order in which processes run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= UNLOCKED;
         rr_ptr  <= '0;
         lock_ch <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            rr_ptr <= (win_ch == CW'(NCH-1)) ? '0 : win_ch + 1'b1;
         if (stall)
            lock_ch <= win_ch;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         err_unexp <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (s_pushout && (count == '0))
            err_unexp <= 1'b1;
      end
   end

   // NOTE: the owner storage has no reset. An entry is only read when count
   // covers it, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push)
         owner_mem[wr_ptr] <= win_ch;
   end

`ifdef NN_BUS_MUX_STATS_EN
   for (genvar g = 0; g < NCH; g++) begin : g_stats
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            stat_acc[g*16 +: 16]   <= '0;
            stat_stall[g*16 +: 16] <= '0;
         end else begin
            if (accept && (win_ch == CW'(g)))
               stat_acc[g*16 +: 16] <= stat_acc[g*16 +: 16] + 16'd1;
            if (m_sel[g] && m_bus_stop[g])
               stat_stall[g*16 +: 16] <= stat_stall[g*16 +: 16] + 16'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_nn_bus_mux.sv
// -----------------------------------------------------------------------------
// tb_nn_bus_mux
//   Directed bench for nn_bus_mux with the default parameters (NCH=4, AW=20,
//   DW=32, RD_DEPTH=4). Inputs change 1 time unit after the rising edge.
//   Combinational outputs are compared 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_nn_bus_mux;

   localparam int NCH = 4, AW = 20, DW = 32, RD_DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    m_sel, m_rw;
   logic [NCH*AW-1:0] m_addr;
   logic [NCH*DW-1:0] m_din;
   logic [DW-1:0]     m_dout;
   logic [NCH-1:0]    m_bus_stop, m_pushout;
   logic              s_sel, s_rw;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_din, s_dout;
   logic              s_bus_stop, s_pushout;
   logic              err_unexp;

   int n_checks = 0;
   int n_fail   = 0;

   nn_bus_mux #(.NCH(NCH), .AW(AW), .DW(DW), .RD_DEPTH(RD_DEPTH)) dut (
      .clk(clk), .reset(reset),
      .m_sel(m_sel), .m_rw(m_rw), .m_addr(m_addr), .m_din(m_din),
      .m_dout(m_dout), .m_bus_stop(m_bus_stop), .m_pushout(m_pushout),
      .s_sel(s_sel), .s_rw(s_rw), .s_addr(s_addr), .s_din(s_din),
      .s_dout(s_dout), .s_bus_stop(s_bus_stop), .s_pushout(s_pushout),
      .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required end before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic sel, input logic rw,
                         input logic [AW-1:0] addr, input logic [DW-1:0] din);
      m_sel[i]            = sel;
      m_rw[i]             = rw;
      m_addr[i*AW +: AW]  = addr;
      m_din[i*DW +: DW]   = din;
   endtask

   task automatic clear_all();
      m_sel = '0; m_rw = '0; m_addr = '0; m_din = '0;
   endtask

   initial begin
      logic [3:0] exp_po [4];
      reset = 1'b1;
      clear_all();
      s_dout = '0; s_bus_stop = 1'b0; s_pushout = 1'b0;
      m_sel = 4'b1010;
      #3;
      // Reset state: bus idle, requesters all see stall.
      check("rst_s_sel", s_sel, 0);
      check("rst_bus_stop", m_bus_stop, 4'b1010);
      check("rst_pushout", m_pushout, 0);
      check("rst_err", err_unexp, 0);
      next();
      next();
      reset = 1'b0;
      clear_all();

      // Round-robin: all four channels write every cycle.
      for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b0, 20'h00100 + 20'(i), 32'hD000_0000 + 32'(i));
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("rr_addr%0d", c), s_addr, 20'h00100 + 20'(c % 4));
         check($sformatf("rr_din%0d", c), s_din, 32'hD000_0000 + 32'(c % 4));
         check($sformatf("rr_stop%0d", c), m_bus_stop, 4'b1111 & ~(4'b0001 << (c % 4)));
         next();
      end
      clear_all();   // rr_ptr now 1

      // Stall lock: ch1 held for 3 stalled cycles, ch2 waits.
      set_ch(1, 1'b1, 1'b0, 20'h00010, 32'h11);
      set_ch(2, 1'b1, 1'b0, 20'h00020, 32'h22);
      s_bus_stop = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("lock_addr%0d", c), s_addr, 20'h00010);
         check($sformatf("lock_stop%0d", c), m_bus_stop, 4'b0110);
         next();
      end
      s_bus_stop = 1'b0;
      #1;
      check("lock_acc_addr", s_addr, 20'h00010);
      check("lock_acc_stop", m_bus_stop, 4'b0100);
      next();
      set_ch(1, 1'b0, 1'b0, '0, '0);
      #1;
      check("lock_ch2_addr", s_addr, 20'h00020);
      check("lock_ch2_stop", m_bus_stop, 4'b0000);
      next();
      clear_all();   // rr_ptr now 3

      // Locked channel drops m_sel: bus idles and the lock is kept.
      set_ch(3, 1'b1, 1'b0, 20'h00030, 32'h33);
      s_bus_stop = 1'b1;
      #1;
      check("drop_addr", s_addr, 20'h00030);
      next();
      set_ch(3, 1'b0, 1'b0, '0, '0);
      set_ch(0, 1'b1, 1'b0, 20'h00040, 32'h44);
      s_bus_stop = 1'b0;
      #1;
      check("drop_s_sel", s_sel, 0);
      check("drop_stop", m_bus_stop, 4'b0001);
      next();
      set_ch(3, 1'b1, 1'b0, 20'h00030, 32'h33);
      #1;
      check("drop_relock_addr", s_addr, 20'h00030);
      check("drop_relock_stop", m_bus_stop, 4'b0001);
      next();
      clear_all();   // rr_ptr now 0

      // Read routing: ch2 read, then ch0 read; data returns in order.
      set_ch(2, 1'b1, 1'b1, 20'h00200, '0);
      #1;
      check("rd2_rw", s_rw, 1);
      check("rd2_addr", s_addr, 20'h00200);
      next();
      clear_all();
      set_ch(0, 1'b1, 1'b1, 20'h00300, '0);
      #1;
      check("rd0_addr", s_addr, 20'h00300);
      next();
      clear_all();
      s_pushout = 1'b1; s_dout = 32'hAAAA0001;
      #1;
      check("po1_vec", m_pushout, 4'b0100);
      check("po1_dout", m_dout, 32'hAAAA0001);
      next();
      s_dout = 32'hBBBB0002;
      #1;
      check("po2_vec", m_pushout, 4'b0001);
      check("po2_dout", m_dout, 32'hBBBB0002);
      next();
      s_pushout = 1'b0;
      #1;
      check("po_idle", m_pushout, 0);
      check("po_err", err_unexp, 0);
      // rr_ptr now 1

      // FIFO full: four reads from ch0, then ch3 read must wait.
      for (int c = 0; c < 4; c++) begin
         set_ch(0, 1'b1, 1'b1, 20'h00400 + 20'(c), '0);
         #1;
         check($sformatf("fill_stop%0d", c), m_bus_stop, 0);
         next();
      end
      clear_all();
      set_ch(3, 1'b1, 1'b1, 20'h00500, '0);
      set_ch(1, 1'b1, 1'b0, 20'h00600, 32'h66);
      #1;
      check("full_wr_addr", s_addr, 20'h00600);
      check("full_wr_rw", s_rw, 0);
      check("full_stop", m_bus_stop, 4'b1000);
      next();
      set_ch(1, 1'b0, 1'b0, '0, '0);
      s_pushout = 1'b1;
      #1;
      check("full_pop_vec", m_pushout, 4'b0001);
      check("full_pop_sel", s_sel, 0);
      check("full_pop_stop", m_bus_stop, 4'b1000);
      next();
      s_pushout = 1'b0;
      #1;
      check("full_rd3_sel", s_sel, 1);
      check("full_rd3_addr", s_addr, 20'h00500);
      check("full_rd3_stop", m_bus_stop, 0);
      next();
      clear_all();   // rr_ptr now 0
      exp_po[0] = 4'b0001; exp_po[1] = 4'b0001; exp_po[2] = 4'b0001; exp_po[3] = 4'b1000;
      s_pushout = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("drain%0d", c), m_pushout, exp_po[c]);
         next();
      end

      // Unexpected pushout with the FIFO empty.
      #1;
      check("unexp_vec", m_pushout, 0);
      next();
      s_pushout = 1'b0;
      #1;
      check("unexp_err", err_unexp, 1);
      next();
      check("unexp_err_sticky", err_unexp, 1);

      // Two reads outstanding, then reset while a write is stalled.
      set_ch(1, 1'b1, 1'b1, 20'h00710, '0);
      next();
      clear_all();
      set_ch(2, 1'b1, 1'b1, 20'h00720, '0);
      next();
      clear_all();
      set_ch(0, 1'b1, 1'b0, 20'h00730, 32'h77);
      s_bus_stop = 1'b1;
      #1;
      check("pre_rst_addr", s_addr, 20'h00730);
      next();
      #2;
      reset = 1'b1;
      s_pushout = 1'b1;
      #1;
      check("mid_rst_sel", s_sel, 0);
      check("mid_rst_err", err_unexp, 0);
      check("mid_rst_stop", m_bus_stop, 4'b0001);
      check("mid_rst_po", m_pushout, 0);
      next();
      reset = 1'b0;
      clear_all();
      s_bus_stop = 1'b0;
      #1;
      check("post_rst_po", m_pushout, 0);
      next();
      s_pushout = 1'b0;
      #1;
      check("post_rst_err", err_unexp, 1);
      set_ch(2, 1'b1, 1'b0, 20'h00740, 32'h88);
      #1;
      check("post_rst_unlocked", s_addr, 20'h00740);
      next();
      clear_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
